// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_responder                                                |
// | Purpose  : Single-outstanding data-memory responder with a configurable  |
// |            wait-state delay. It handles byte, halfword and word          |
// |            loads/stores to an internal 32-bit-wide memory. Misaligned,   |
// |            reserved-size and out-of-range accesses are rejected.         |
// | Ports    : clk, rstn (sync, active-low)                                  |
// |            req_valid/req_ready : request handshake                       |
// |            req_wen/req_size/req_addr/req_wdata : request fields          |
// |            rsp_valid/rsp_ready : response handshake                      |
// |            rsp_rdata/rsp_err   : response payload                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [0:DEPTH-1];

  // Operation being resolved this cycle. With zero wait states the response
  // is produced at the acceptance edge, so the live request fields are used
  // while idle; otherwise the latched copy is used.
  logic                  op_wen;
  logic [1:0]            op_size;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic                  range_err;
  logic                  op_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [4:0]            lane_shift;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           load_data;
  logic [3:0]            byte_en;
  logic [31:0]           wr_lanes;
  logic                  enter_resp;
  logic                  mem_we;

  always_comb begin
    if (state_q == S_IDLE) begin
      op_wen   = req_wen;
      op_size  = req_size;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end else begin
      op_wen   = wen_q;
      op_size  = size_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  // Any set bit above the implemented word index is out of range.
  generate
    if (ADDR_WIDTH < 30) begin : g_range_chk
      assign range_err = |op_addr[31:ADDR_WIDTH+2];
    end else begin : g_range_full
      assign range_err = 1'b0;
    end
  endgenerate

  assign op_err = (op_size == 2'b11)
                | ((op_size == 2'b01) && op_addr[0])
                | ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
                | range_err;

  assign word_idx   = op_addr[ADDR_WIDTH+1:2];
  assign lane       = op_addr[1:0];
  assign lane_shift = {lane, 3'b000};
  assign rd_word    = mem[word_idx];
  assign rd_shift   = rd_word >> lane_shift;

  // Loads are right-justified and zero-extended.
  always_comb begin
    case (op_size)
      2'b00:   load_data = {24'd0, rd_shift[7:0]};
      2'b01:   load_data = lane[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes; byte enables pick the target lanes.
  always_comb begin
    case (op_size)
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        byte_en  = 4'b1111;
        wr_lanes = op_wdata;
      end
      default: begin
        byte_en  = 4'b0000;
        wr_lanes = op_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ready_q && req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read sampling and store commit happen only on the edge entering RESP.
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = op_err;
      rsp_rdata_d = (op_err || op_wen) ? 32'd0 : load_data;
    end

    ready_d = (state_d == S_IDLE);
  end

  assign mem_we = enter_resp && op_wen && !op_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory contents survive reset; a reset edge only blocks the commit.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                             |
// | Purpose  : Directed self-checking bench for dmem_responder with a        |
// |            transaction-level reference model and per-cycle compare.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int W  = 2;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit f_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)
        || (a >= (32'd4 << AW));
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] s, input int ln);
    if (s == 2'd0) return (w >> (8 * ln)) & 32'hFF;
    if (s == 2'd1) return (w >> (16 * (ln / 2))) & 32'hFFFF;
    return w;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] w, input logic [1:0] s,
                                          input int ln, input logic [31:0] d);
    logic [31:0] m;
    if (s == 2'd0)      m = 32'hFF << (8 * ln);
    else if (s == 2'd1) m = 32'hFFFF << (16 * (ln / 2));
    else                m = 32'hFFFF_FFFF;
    return (w & ~m) | ((d << (8 * ((s == 2'd0) ? ln : (s == 2'd1) ? 2 * (ln / 2) : 0))) & m);
  endfunction

  logic [31:0] mmem   [0:(1<<AW)-1];
  bit          mvalid [0:(1<<AW)-1];
  int          cyc = 0;
  int          acc = 0;
  bit          pend = 1'b0;
  bit          up = 1'b0;
  bit          in_rst = 1'b1;
  logic        p_wen;
  logic [1:0]  p_size;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] exp_rdata = 32'd0;
  bit          exp_err = 1'b0;
  bit          exp_known = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      pend   <= 1'b0;
      up     <= 1'b0;
      in_rst <= 1'b1;
    end else begin
      in_rst <= 1'b0;
      up     <= 1'b1;
      if (pend) begin
        if (cyc - acc == W) begin
          exp_err   <= f_err(p_size, p_addr);
          exp_known <= f_err(p_size, p_addr) || p_wen || mvalid[(p_addr >> 2) % (1 << AW)];
          if (f_err(p_size, p_addr) || p_wen) exp_rdata <= 32'd0;
          else exp_rdata <= f_load(mmem[(p_addr >> 2) % (1 << AW)], p_size, p_addr % 4);
          if (!f_err(p_size, p_addr) && p_wen) begin
            mmem[(p_addr >> 2) % (1 << AW)] <=
              f_store(mmem[(p_addr >> 2) % (1 << AW)], p_size, p_addr % 4, p_wdata);
            mvalid[(p_addr >> 2) % (1 << AW)] <= 1'b1;
          end
        end
        if ((cyc - acc >= W + 1) && rsp_ready) pend <= 1'b0;
      end else if (up && req_valid) begin
        pend    <= 1'b1;
        acc     <= cyc;
        p_wen   <= req_wen;
        p_size  <= req_size;
        p_addr  <= req_addr;
        p_wdata <= req_wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit ev;
  always @(negedge clk) begin
    if (cyc > 0) begin
      ev = pend && (cyc - acc >= W + 1);
      check("req_ready", req_ready, up && !pend);
      check("rsp_valid", rsp_valid, ev);
      if (ev) begin
        check("rsp_err", rsp_err, exp_err);
        if (exp_known) check("rsp_rdata", rsp_rdata, exp_rdata);
      end
      if (in_rst) begin
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", rsp_err, 32'd0);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  // Called and returns just after a falling edge.
  task automatic txn(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_er,
                     input int hold, input bit noise);
    int  lat;
    bit  ok;
    req_valid = 1'b1;
    req_wen   = wen;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (noise) begin
      // Garbage request while busy; must be ignored.
      req_wen   = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h40;
      req_wdata = 32'h0BAD0BAD;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    check("latency", lat, W + 1);
    check("lit_rdata", rsp_rdata, exp_rd);
    check("lit_err", rsp_err, exp_er);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", rsp_err, exp_er);
      check("hold_ready", req_ready, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ready_after_rsp", req_ready, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 32'd0);
    check("rst_valid", rsp_valid, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_post_rst", req_ready, 32'd1);

    txn(1'b1, 2'd2, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
    txn(1'b1, 2'd2, 32'h40,   32'h11223344, 32'h0,        1'b0, 0, 1'b0);
    txn(1'b1, 2'd0, 32'h41,   32'h000000AA, 32'h0,        1'b0, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h40,   32'h0,        32'h1122AA44, 1'b0, 0, 1'b0);
    txn(1'b0, 2'd0, 32'h43,   32'h0,        32'h00000011, 1'b0, 0, 1'b0);
    txn(1'b0, 2'd1, 32'h42,   32'h0,        32'h00001122, 1'b0, 0, 1'b0);
    txn(1'b0, 2'd1, 32'h41,   32'h0,        32'h0,        1'b1, 0, 1'b0);
    txn(1'b1, 2'd2, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0, 0, 1'b0);
    txn(1'b1, 2'd2, 32'h1002, 32'h12345678, 32'h0,        1'b1, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h40,   32'h0,        32'h1122AA44, 1'b0, 5, 1'b1);
    txn(1'b1, 2'd1, 32'h42,   32'h0000BEEF, 32'h0,        1'b0, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h40,   32'h0,        32'hBEEFAA44, 1'b0, 0, 1'b0);
    txn(1'b1, 2'd0, 32'h43,   32'hFFFFFF77, 32'h0,        1'b0, 0, 1'b0);
    txn(1'b0, 2'd1, 32'h40,   32'h0,        32'h0000AA44, 1'b0, 0, 1'b0);
    txn(1'b0, 2'd0, 32'h40,   32'h0,        32'h00000044, 1'b0, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h40,   32'h0,        32'h77EFAA44, 1'b0, 0, 1'b0);

    // Store abandoned by reset during its wait states.
    txn(1'b1, 2'd2, 32'h80,   32'h12345678, 32'h0,        1'b0, 0, 1'b0);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h80;
    req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rstn      = 1'b0;
    @(negedge clk);
    check("midrst_ready", req_ready, 32'd0);
    check("midrst_valid", rsp_valid, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", req_ready, 32'd1);
    txn(1'b0, 2'd2, 32'h80,   32'h0,        32'h12345678, 1'b0, 0, 1'b0);

    txn(1'b0, 2'd2, 32'h1000, 32'h0,        32'h0,        1'b1, 0, 1'b0);
    txn(1'b0, 2'd3, 32'h40,   32'h0,        32'h0,        1'b1, 0, 1'b0);
    txn(1'b1, 2'd3, 32'h44,   32'h99999999, 32'h0,        1'b1, 0, 1'b1);
    txn(1'b1, 2'd2, 32'h42,   32'h99999999, 32'h0,        1'b1, 0, 1'b0);
    txn(1'b0, 2'd2, 32'h40,   32'h0,        32'h77EFAA44, 1'b0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
